// File: rtl/prio_code_fifo.sv
// prio_code_fifo
//   Captures priority-encoder results into a 4-entry first-word-fall-through
//   FIFO. Each sampled code is classified as legal (0x00-0x0F), none (0xF0)
//   or illegal (anything else). Consecutive repeats of the same legal code
//   are collapsed into one entry. Lost pushes and illegal codes raise sticky
//   flags.
//
// Ports
//   clk        single clock, all state updates on its rising edge
//   rst_n      synchronous active-low reset
//   code_in    encoder code, sampled when code_vld=1
//   code_vld   qualifies code_in
//   out_code   oldest stored index (0 when empty)
//   out_vld    FIFO holds at least one entry
//   out_rdy    consumer ready; pop when out_vld && out_rdy
//   count      number of stored entries, 0-4
//   ovf        sticky: a push was lost because the FIFO was full
//   bad        sticky: an illegal code was sampled
//   clr_flags  clears ovf and bad (a set event in the same cycle wins)

module prio_code_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] code_in,
    input  logic       code_vld,
    output logic [3:0] out_code,
    output logic       out_vld,
    input  logic       out_rdy,
    output logic [2:0] count,
    output logic       ovf,
    output logic       bad,
    input  logic       clr_flags
);

    localparam logic [2:0] FULL_COUNT = 3'(DEPTH);

    logic [3:0] mem [DEPTH];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [3:0] last_code;
    logic       last_vld;

    logic is_legal;
    logic is_none;
    logic is_illegal;
    logic is_dup;
    logic push_cand;
    logic pop;
    logic push;
    logic lost;

    // NOTE: every signal driven from always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        is_legal   = 1'b0;
        is_none    = 1'b0;
        is_illegal = 1'b0;
        if (code_vld) begin
            if (code_in[7:4] == 4'h0)
                is_legal = 1'b1;
            else if (code_in == 8'hF0)
                is_none = 1'b1;
            else
                is_illegal = 1'b1;
        end

        // A repeat of the last accepted code carries no new information.
        is_dup    = last_vld && (last_code == code_in[3:0]);
        push_cand = is_legal && !is_dup;

        // out_vld gates the pop, so an empty FIFO can never be popped.
        pop  = out_vld && out_rdy;
        // A pop in the same cycle frees a slot even when full.
        push = push_cand && ((count != FULL_COUNT) || pop);
        lost = push_cand && (count == FULL_COUNT) && !pop;
    end

    assign out_vld  = (count != 3'd0);
    assign out_code = out_vld ? mem[rd_ptr] : 4'h0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
            count     <= 3'd0;
            last_vld  <= 1'b0;
            last_code <= 4'h0;
            ovf       <= 1'b0;
            bad       <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 2'd1;
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            count <= count + 3'(push) - 3'(pop);

            if (is_none) begin
                last_vld <= 1'b0;
            end else if (push) begin
                last_vld  <= 1'b1;
                last_code <= code_in[3:0];
            end

            // Set events take priority over the clear request.
            if (lost)
                ovf <= 1'b1;
            else if (clr_flags)
                ovf <= 1'b0;

            if (is_illegal)
                bad <= 1'b1;
            else if (clr_flags)
                bad <= 1'b0;
        end
    end

    // NOTE: the storage array has no reset; count and the pointers alone
    // decide which entries are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= code_in[3:0];
    end

endmodule

// File: tb/tb_prio_code_fifo.sv
// tb_prio_code_fifo
//   Directed, table-driven bench for prio_code_fifo. Each table row holds the
//   inputs for one clock cycle and the outputs expected just after that edge.
//   A hand-written drain sequence follows the table.

module tb_prio_code_fifo;

    logic       clk;
    logic       rst_n;
    logic [7:0] code_in;
    logic       code_vld;
    logic [3:0] out_code;
    logic       out_vld;
    logic       out_rdy;
    logic [2:0] count;
    logic       ovf;
    logic       bad;
    logic       clr_flags;

    int n_checks = 0;
    int n_fail   = 0;

    prio_code_fifo #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .code_in   (code_in),
        .code_vld  (code_vld),
        .out_code  (out_code),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .count     (count),
        .ovf       (ovf),
        .bad       (bad),
        .clr_flags (clr_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       vld;
        logic [7:0] code;
        logic       rdy;
        logic       clr;
        logic       e_vld;
        logic [3:0] e_code;
        logic [2:0] e_cnt;
        logic       e_ovf;
        logic       e_bad;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int row,
                         input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s (row %0d): got 0x%0h, expected 0x%0h",
                     name, row, actual, expected);
        end
    endtask

    task automatic add(input logic r, input logic v, input logic [7:0] c,
                       input logic rdy, input logic clr,
                       input logic ev, input logic [3:0] ec, input logic [2:0] en,
                       input logic eo, input logic eb);
        vec_t t;
        t.rst_n = r;  t.vld = v;  t.code = c;  t.rdy = rdy;  t.clr = clr;
        t.e_vld = ev; t.e_code = ec; t.e_cnt = en; t.e_ovf = eo; t.e_bad = eb;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic r, input logic v, input logic [7:0] c,
                         input logic rdy, input logic clr);
        rst_n = r; code_vld = v; code_in = c; out_rdy = rdy; clr_flags = clr;
    endtask

    logic [3:0] exp_q[$];
    logic [3:0] exp_head;
    int         cycles;

    initial begin
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        //   rst  vld code   rdy  clr   vld code cnt ovf bad
        // reset, including a push attempt that reset must override
        add(0, 0, 8'h00, 0, 0,  0, 4'h0, 3'd0, 0, 0);
        add(0, 1, 8'h05, 1, 1,  0, 4'h0, 3'd0, 0, 0);
        // single push, visible one cycle later
        add(1, 1, 8'h0D, 0, 0,  1, 4'hD, 3'd1, 0, 0);
        // duplicate dropped, none invalidates last code, repeat accepted
        add(1, 1, 8'h0D, 0, 0,  1, 4'hD, 3'd1, 0, 0);
        add(1, 1, 8'hF0, 0, 0,  1, 4'hD, 3'd1, 0, 0);
        add(1, 1, 8'h0D, 0, 0,  1, 4'hD, 3'd2, 0, 0);
        add(1, 0, 8'h00, 1, 0,  1, 4'hD, 3'd1, 0, 0);
        add(1, 0, 8'h00, 1, 0,  0, 4'h0, 3'd0, 0, 0);
        // fill to 4, fifth push overflows, then drain in order
        add(1, 1, 8'h00, 0, 0,  1, 4'h0, 3'd1, 0, 0);
        add(1, 1, 8'h01, 0, 0,  1, 4'h0, 3'd2, 0, 0);
        add(1, 1, 8'h02, 0, 0,  1, 4'h0, 3'd3, 0, 0);
        add(1, 1, 8'h03, 0, 0,  1, 4'h0, 3'd4, 0, 0);
        add(1, 1, 8'h04, 0, 0,  1, 4'h0, 3'd4, 1, 0);
        add(1, 0, 8'h00, 1, 0,  1, 4'h1, 3'd3, 1, 0);
        add(1, 0, 8'h00, 1, 0,  1, 4'h2, 3'd2, 1, 0);
        add(1, 0, 8'h00, 1, 0,  1, 4'h3, 3'd1, 1, 0);
        add(1, 0, 8'h00, 1, 0,  0, 4'h0, 3'd0, 1, 0);
        add(1, 1, 8'hF0, 0, 1,  0, 4'h0, 3'd0, 0, 0);
        // full FIFO with simultaneous push and pop
        add(1, 1, 8'h0A, 0, 0,  1, 4'hA, 3'd1, 0, 0);
        add(1, 1, 8'h0B, 0, 0,  1, 4'hA, 3'd2, 0, 0);
        add(1, 1, 8'h0C, 0, 0,  1, 4'hA, 3'd3, 0, 0);
        add(1, 1, 8'h0E, 0, 0,  1, 4'hA, 3'd4, 0, 0);
        add(1, 1, 8'h0F, 1, 0,  1, 4'hB, 3'd4, 0, 0);
        add(1, 0, 8'h00, 1, 0,  1, 4'hC, 3'd3, 0, 0);
        add(1, 0, 8'h00, 1, 0,  1, 4'hE, 3'd2, 0, 0);
        add(1, 0, 8'h00, 1, 0,  1, 4'hF, 3'd1, 0, 0);
        add(1, 0, 8'h00, 1, 0,  0, 4'h0, 3'd0, 0, 0);
        // illegal codes, clear, and set-beats-clear
        add(1, 1, 8'h37, 0, 0,  0, 4'h0, 3'd0, 0, 1);
        add(1, 1, 8'hF0, 0, 1,  0, 4'h0, 3'd0, 0, 0);
        add(1, 1, 8'h37, 0, 0,  0, 4'h0, 3'd0, 0, 1);
        add(1, 1, 8'h80, 0, 1,  0, 4'h0, 3'd0, 0, 1);
        add(1, 1, 8'hF0, 0, 1,  0, 4'h0, 3'd0, 0, 0);
        // illegal code leaves last code intact: following 0x07 is a duplicate
        add(1, 1, 8'h07, 0, 0,  1, 4'h7, 3'd1, 0, 0);
        add(1, 1, 8'h99, 0, 0,  1, 4'h7, 3'd1, 0, 1);
        add(1, 1, 8'h07, 0, 0,  1, 4'h7, 3'd1, 0, 1);
        add(1, 1, 8'hF0, 0, 1,  1, 4'h7, 3'd1, 0, 0);
        // overflow coincident with clear: ovf must be set, then hold
        add(1, 1, 8'h01, 0, 0,  1, 4'h7, 3'd2, 0, 0);
        add(1, 1, 8'h02, 0, 0,  1, 4'h7, 3'd3, 0, 0);
        add(1, 1, 8'h03, 0, 0,  1, 4'h7, 3'd4, 0, 0);
        add(1, 1, 8'h04, 0, 1,  1, 4'h7, 3'd4, 1, 0);
        add(1, 0, 8'h00, 0, 0,  1, 4'h7, 3'd4, 1, 0);
        // mid-operation reset forgets last code and entries
        add(0, 0, 8'h00, 0, 0,  0, 4'h0, 3'd0, 0, 0);
        add(1, 1, 8'h05, 0, 0,  1, 4'h5, 3'd1, 0, 0);
        add(1, 1, 8'h06, 0, 0,  1, 4'h5, 3'd2, 0, 0);
        add(1, 1, 8'h05, 0, 0,  1, 4'h5, 3'd3, 0, 0);
        add(1, 1, 8'h55, 0, 0,  1, 4'h5, 3'd3, 0, 1);
        add(0, 0, 8'h00, 0, 0,  0, 4'h0, 3'd0, 0, 0);
        // push into empty FIFO with rdy high: no bypass, no pop
        add(1, 1, 8'h05, 1, 0,  1, 4'h5, 3'd1, 0, 0);
        add(1, 0, 8'h00, 1, 0,  0, 4'h0, 3'd0, 0, 0);
        // push and pop together at count 1 keeps count
        add(1, 1, 8'h09, 0, 0,  1, 4'h9, 3'd1, 0, 0);
        add(1, 1, 8'h08, 1, 0,  1, 4'h8, 3'd1, 0, 0);
        add(1, 0, 8'h00, 1, 0,  0, 4'h0, 3'd0, 0, 0);

        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].vld, vecs[i].code, vecs[i].rdy, vecs[i].clr);
            @(posedge clk);
            #1;
            check("out_vld",  i, 32'(out_vld),  32'(vecs[i].e_vld));
            check("out_code", i, 32'(out_code), 32'(vecs[i].e_code));
            check("count",    i, 32'(count),    32'(vecs[i].e_cnt));
            check("ovf",      i, 32'(ovf),      32'(vecs[i].e_ovf));
            check("bad",      i, 32'(bad),      32'(vecs[i].e_bad));
        end

        // Hand sequence: load three entries (pointers have already wrapped
        // several times), then drain with a bounded wait.
        exp_q = '{4'hC, 4'h3, 4'hC};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, {4'h0, exp_q[i]}, 1'b0, 1'b0);
            @(posedge clk);
            #1;
        end
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check("seq_count", -1, 32'(count), 32'd3);

        out_rdy = 1'b1;
        cycles  = 0;
        while (out_vld && cycles < 10) begin
            if (exp_q.size() == 0) begin
                check("seq_extra_entry", -1, 32'(out_vld), 32'd0);
                break;
            end
            exp_head = exp_q.pop_front();
            check("seq_head", -1, 32'(out_code), 32'(exp_head));
            @(posedge clk);
            #1;
            cycles++;
        end
        check("seq_drained", -1, 32'(exp_q.size()), 32'd0);
        check("seq_empty",   -1, 32'(out_vld), 32'd0);
        check("seq_code0",   -1, 32'(out_code), 32'd0);
        out_rdy = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
